// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_pkg
// Description : Shared arbiter constants and the round-robin winner function.
// Revision    : 1.0
// ============================================================================
package mux4_rr_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int HOLD_W           = 8;

    // First set request searching circularly from ptr+1; k=4 wraps back to ptr itself.
    function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_mux
// Description : 4:1 data mux with active-low enable; output is zero when disabled.
// Revision    : 1.0
// ============================================================================
module mux4_rr_arbiter_mux #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr,
    input  logic             enable,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        if (!enable) begin
            case (addr)
                2'd0:    out = in0;
                2'd1:    out = in1;
                2'd2:    out = in2;
                default: out = in3;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Four-way round-robin arbiter with hold-limit preemption driving
//               a shared 4:1 data mux.
// Revision    : 1.0
// ============================================================================
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             mux_en_n,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]        state;
    logic [0:0]        next_state;
    logic [1:0]        ptr;
    logic [1:0]        next_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic [3:0]        next_gnt;
    logic [1:0]        next_sel;
    logic [1:0]        winner;
    logic              other_pending;

    assign winner        = rr_next(req, ptr);
    assign other_pending = |(req & ~gnt);

    // ptr resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            gnt      <= next_gnt;
            sel      <= next_sel;
            ptr      <= next_ptr;
            hold_cnt <= next_hold;
        end
    end

    always_comb begin
        next_state = state;
        next_gnt   = gnt;
        next_sel   = sel;
        next_ptr   = ptr;
        next_hold  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    next_state = ST_GRANT;
                    next_gnt   = 4'b0001 << winner;
                    next_sel   = winner;
                    next_ptr   = winner;
                    next_hold  = '0;
                end
            end
            ST_GRANT: begin
                // Release, or preempt once the hold limit is reached with someone waiting.
                if (!req[sel] || (hold_cnt == HOLD_LAST && other_pending)) begin
                    next_state = ST_IDLE;
                    next_gnt   = '0;
                end else if (hold_cnt != HOLD_LAST) begin
                    next_hold = hold_cnt + 8'd1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_gnt   = '0;
            end
        endcase
    end

    always_comb begin
        mux_en_n = ~|gnt;
        busy     = (state == ST_GRANT);
    end

    mux4_rr_arbiter_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .addr   (sel),
        .enable (mux_en_n),
        .in0    (din0),
        .in1    (din1),
        .in2    (din2),
        .in3    (din3),
        .out    (dout)
    );

endmodule
`default_nettype wire
